// File: rtl/spi_mem_target_if.sv
// SPI pin bundle between an SPI master and spi_mem_target.
// The slave modport is the target's view; the master modport is the driver's view.
// dbg_state_o carries the target FSM state encoding for observation.
interface spi_mem_target_if;
    logic       spi_sclk_i;
    logic       spi_cs_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic       busy_o;
    logic       cmd_err_o;
    logic [2:0] dbg_state_o;

    modport slave (
        input  spi_sclk_i,
        input  spi_cs_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output busy_o,
        output cmd_err_o,
        output dbg_state_o
    );

    modport master (
        output spi_sclk_i,
        output spi_cs_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  busy_o,
        input  cmd_err_o,
        input  dbg_state_o
    );
endinterface

// File: rtl/spi_mem_target.sv
// spi_mem_target: SPI mode-0 target backed by a 2^ADDR_WIDTH x 8 register array.
// Frame: CMD, ADDR_HI, ADDR_LO, then data bytes until CS rises (0x03 READ, 0x02 WRITE).
// SCLK/CS/MOSI are oversampled on clk_core_i through SYNC_STAGES flops.
// Optional macro SPI_MEM_TARGET_BACKDOOR_EN adds a backdoor memory port.
module spi_mem_target #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_core_i,
    input  logic                  rst_n_i,
    spi_mem_target_if.slave       spi
`ifdef SPI_MEM_TARGET_BACKDOOR_EN
    ,
    // Backdoor handshake: a write transfers on a clk_core_i edge where
    // bd_we_i (valid) and bd_ready_o (ready) are both high; otherwise it is
    // dropped, never held. bd_ready_o is low for the whole SPI frame.
    input  logic                  bd_we_i,
    input  logic [ADDR_WIDTH-1:0] bd_addr_i,
    input  logic [7:0]            bd_wdata_i,
    output logic [7:0]            bd_rdata_o,
    output logic                  bd_ready_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [7:0]            r_mem [0:(2**ADDR_WIDTH)-1];

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_rx;
    logic [7:0]            r_tx;
    logic [7:0]            r_addr_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_read;
    logic                  r_load_pend;
    logic                  r_miso;
    logic                  r_busy;
    logic                  r_cmd_err;

    logic                  w_sclk;
    logic                  w_cs;
    logic                  w_mosi;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cs_rise;
    logic                  w_cs_fall;
    logic                  w_last;
    logic                  w_counting;
    logic [7:0]            w_byte;
    logic [15:0]           w_addr16;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_spi_we;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    // SCLK edges only count while CS is low; CS edges need a real prior level,
    // so a CS held low through reset never opens a frame.
    assign w_rise      = w_sclk & ~r_sclk_d & ~w_cs;
    assign w_fall      = ~w_sclk & r_sclk_d & ~w_cs;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_last      = (r_bit_cnt == 3'd7);
    assign w_byte      = {r_rx, w_mosi};
    assign w_addr16    = {r_addr_hi, w_byte};
    assign w_addr_next = r_addr + ADDR_ONE;
    assign w_counting  = (r_state == ST_CMD) || (r_state == ST_ADDR_HI) ||
                         (r_state == ST_ADDR_LO) || (r_state == ST_RD_DATA) ||
                         (r_state == ST_WR_DATA);
    assign w_spi_we    = (r_state == ST_WR_DATA) && w_rise && w_last;

    generate
        if (ADDR_WIDTH < 16) begin : g_addr_trim
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^w_addr16[15:ADDR_WIDTH];
        end
    endgenerate

    // Synchronise the SPI pins and keep one-cycle-old copies for edge detection.
    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi.spi_cs_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi_i};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    // Frame FSM: decodes command/address, shifts MISO, tracks busy and errors.
    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 8'd0;
            r_addr_hi   <= 8'd0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_err   <= 1'b0;
            r_load_pend <= 1'b0;
            if (r_load_pend) begin
                r_tx <= r_mem[r_addr];
            end
            if (w_cs_rise) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else if (w_cs_fall) begin
                r_state   <= ST_CMD;
                r_busy    <= 1'b1;
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else begin
                if (w_rise && w_counting) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                case (r_state)
                    ST_CMD: begin
                        if (w_rise && w_last) begin
                            if (w_byte == 8'h03) begin
                                r_is_read <= 1'b1;
                                r_state   <= ST_ADDR_HI;
                            end else if (w_byte == 8'h02) begin
                                r_is_read <= 1'b0;
                                r_state   <= ST_ADDR_HI;
                            end else begin
                                r_cmd_err <= 1'b1;
                                r_state   <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_HI: begin
                        if (w_rise && w_last) begin
                            r_addr_hi <= w_byte;
                            r_state   <= ST_ADDR_LO;
                        end
                    end
                    ST_ADDR_LO: begin
                        if (w_rise && w_last) begin
                            r_addr <= w_addr16[ADDR_WIDTH-1:0];
                            if (r_is_read) begin
                                r_load_pend <= 1'b1;
                                r_state     <= ST_RD_DATA;
                            end else begin
                                r_state     <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (w_rise && w_last) begin
                            r_tx   <= r_mem[w_addr_next];
                            r_addr <= w_addr_next;
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_rise && w_last) begin
                            r_addr <= w_addr_next;
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SPI_MEM_TARGET_BACKDOOR_EN
    logic w_bd_we;
    assign w_bd_we    = bd_we_i && !r_busy && !w_spi_we;
    assign bd_rdata_o = r_mem[bd_addr_i];
    assign bd_ready_o = !r_busy;

    // Memory write port: a completed SPI data byte has priority over the backdoor.
    always_ff @(posedge clk_core_i) begin
        if (w_spi_we) begin
            r_mem[r_addr] <= w_byte;
        end else if (w_bd_we) begin
            r_mem[bd_addr_i] <= bd_wdata_i;
        end
    end
`else
    // Memory write port: commits a completed SPI data byte; contents survive reset.
    always_ff @(posedge clk_core_i) begin
        if (w_spi_we) begin
            r_mem[r_addr] <= w_byte;
        end
    end
`endif

    assign spi.spi_miso_o  = r_miso;
    assign spi.busy_o      = r_busy;
    assign spi.cmd_err_o   = r_cmd_err;
    assign spi.dbg_state_o = r_state;

endmodule

// File: tb/tb_spi_mem_target.sv
// Bench for spi_mem_target (default build, ADDR_WIDTH=8, SYNC_STAGES=2).
// Drives SPI mode-0 frames from tasks; read data is checked against a queue of
// expected bytes pushed before each read frame.
module tb_spi_mem_target;
  localparam int HALF = 60;  // SCLK half period in ns (core clock 10 ns)
  localparam logic [2:0] ST_IDLE_CODE = 3'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  spi_mem_target_if u_if ();

  spi_mem_target #(
    .ADDR_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_core_i(clk),
    .rst_n_i   (rst_n),
    .spi       (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_err_pulses = 0;
  int n_miso_ones = 0;
  bit chk_miso_zero = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[4];

  // output monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (u_if.cmd_err_o === 1'b1) n_err_pulses++;
    if (chk_miso_zero && u_if.spi_miso_o !== 1'b0) n_miso_ones++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      u_if.spi_mosi_i = tx[7-i];
      #(HALF);
      rx[7-i] = u_if.spi_miso_o;
      u_if.spi_sclk_i = 1'b1;
      #(HALF);
      u_if.spi_sclk_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic frame_begin();
    u_if.spi_cs_i = 1'b0;
    #(2*HALF);
    check("busy_frame_start", u_if.busy_o, 1'b1);
  endtask

  task automatic frame_end();
    #(HALF);
    check("busy_frame_end", u_if.busy_o, 1'b1);
    u_if.spi_cs_i = 1'b1;
    #(4*HALF);
    check("busy_after_frame", u_if.busy_o, 1'b0);
  endtask

  task automatic spi_write(input logic [15:0] addr, input logic [7:0] d0,
                           input logic [7:0] d1, input int n);
    logic [7:0] rx;
    chk_miso_zero = 1'b1;
    n_miso_ones = 0;
    frame_begin();
    spi_byte(8'h02, rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    spi_byte(d0, rx);
    if (n > 1) spi_byte(d1, rx);
    frame_end();
    chk_miso_zero = 1'b0;
    check("wr_miso_zero", n_miso_ones, 0);
  endtask

  task automatic spi_read(input logic [15:0] addr, input int n);
    logic [7:0] rx;
    frame_begin();
    spi_byte(8'h03, rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_data: got %0h with no expected byte queued", rx);
      end else begin
        check("rd_data", rx, exp_q.pop_front());
      end
    end
    frame_end();
  endtask

  // watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] rnd;
    int pulses0;

    u_if.spi_sclk_i = 1'b0;
    u_if.spi_cs_i   = 1'b1;
    u_if.spi_mosi_i = 1'b0;

    // reset state
    rst_n = 1'b0;
    #50;
    check("rst_miso", u_if.spi_miso_o, 1'b0);
    check("rst_busy", u_if.busy_o, 1'b0);
    check("rst_cmd_err", u_if.cmd_err_o, 1'b0);
    check("rst_state", u_if.dbg_state_o, ST_IDLE_CODE);
    @(negedge clk);
    rst_n = 1'b1;
    #200;

    // table-driven single-byte write then read
    rnd = 8'($urandom_range(0, 255));
    vecs[0] = '{16'h0010, 8'hA5, 16'h0010, 8'hA5};
    vecs[1] = '{16'h0034, 8'h5A, 16'h1234, 8'h5A};
    vecs[2] = '{16'hAB55, 8'h66, 16'h0055, 8'h66};
    vecs[3] = '{16'h0080, rnd,   16'hFF80, rnd};
    for (int i = 0; i < 4; i++) begin
      spi_write(vecs[i].wr_addr, vecs[i].wr_data, 8'h00, 1);
      exp_q.push_back(vecs[i].exp_data);
      spi_read(vecs[i].rd_addr, 1);
    end

    // two-byte read with auto-increment
    spi_write(16'h0020, 8'h3C, 8'hC3, 2);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    spi_read(16'h0020, 2);

    // address wrap at top of memory
    spi_write(16'h00FF, 8'h11, 8'h22, 2);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    spi_read(16'h00FF, 2);
    exp_q.push_back(8'h22);
    spi_read(16'h0000, 1);

    // unknown command: one error pulse, MISO quiet, memory untouched
    pulses0 = n_err_pulses;
    n_miso_ones = 0;
    chk_miso_zero = 1'b1;
    frame_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'hFF, rx);
    frame_end();
    chk_miso_zero = 1'b0;
    check("bad_cmd_pulses", n_err_pulses - pulses0, 1);
    check("bad_cmd_miso", n_miso_ones, 0);
    exp_q.push_back(8'hA5);
    spi_read(16'h0010, 1);

    // write aborted after 5 data bits
    frame_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_bits(8'h00, 5, rx);
    #(HALF);
    u_if.spi_cs_i = 1'b1;
    #(4*HALF);
    check("abort_state", u_if.dbg_state_o, ST_IDLE_CODE);
    check("abort_busy", u_if.busy_o, 1'b0);
    exp_q.push_back(8'hA5);
    spi_read(16'h0010, 1);

    // reset pulsed mid-read
    frame_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_bits(8'h00, 3, rx);
    #(HALF);
    check("pre_reset_miso", u_if.spi_miso_o, 1'b1);
    rst_n = 1'b0;
    #20;
    check("midrst_miso", u_if.spi_miso_o, 1'b0);
    check("midrst_busy", u_if.busy_o, 1'b0);
    check("midrst_cmd_err", u_if.cmd_err_o, 1'b0);
    check("midrst_state", u_if.dbg_state_o, ST_IDLE_CODE);
    rst_n = 1'b1;
    spi_bits(8'hFF, 5, rx);
    #(HALF);
    check("post_rst_busy", u_if.busy_o, 1'b0);
    check("post_rst_state", u_if.dbg_state_o, ST_IDLE_CODE);
    u_if.spi_cs_i = 1'b1;
    #(4*HALF);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    spi_read(16'h0020, 2);

    check("queue_drained", exp_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
